// File: rtl/aes_inv_key_expansion.sv
// Iterative inverse AES key schedule for the decrypt datapath.
// Starts from the last Nk words of an expanded schedule and walks it backwards one word per
// cycle, presenting round keys Nr down to 0 on a valid/ready handshake.
// Optional build macro AES_INV_MIXCOL_EN: rounds 1..Nr-1 are output with InvMixColumns applied
// per column (equivalent inverse cipher keys); undefined gives raw round keys.

package aes_pkg;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // RCON[0] is never used by the schedule; index n holds x^(n-1) in GF(2^8).
   localparam logic [7:0] RCON [11] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Words are big-endian by byte: bits [31:24] are the first byte of the word.
   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

`ifdef AES_INV_MIXCOL_EN
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int n = 0; n < 4; n++) begin
         a[n]  = c[31 - 8 * n -: 8];
         x2    = xtime(a[n]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[n] = x8 ^ a[n];
         mb[n] = x8 ^ x2 ^ a[n];
         md[n] = x8 ^ x4 ^ a[n];
         me[n] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction
`endif

endpackage

module aes_inv_key_expansion
   import aes_pkg::*;
#(
   parameter int unsigned Nk = 4,
   parameter int unsigned Nr = Nk + 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic [32*Nk-1:0]           last_key,
   output logic                       rkey_valid,
   input  logic                       rkey_ready,
   output logic [127:0]               rkey,
   output logic [$clog2(Nr+1)-1:0]    rkey_round,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned J0 = 4 * (Nr + 1) - Nk;
   // Wide enough for 4*r and for the forward index j-1+Nk (max 4*Nr+3).
   localparam int unsigned CW = $clog2(4 * (Nr + 1));
   localparam int unsigned RW = $clog2(Nr + 1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e          state_q, state_d;
   logic [31:0]     win_q [Nk];
   logic [31:0]     win_d [Nk];
   logic [CW-1:0]   j_q, j_d;
   logic [RW-1:0]   r_q, r_d;
   logic [127:0]    key_hold_q, key_hold_d;
   logic [RW-1:0]   round_hold_q, round_hold_d;
   logic            done_q, done_d;

   logic [CW-1:0]   r4;
   logic [CW-1:0]   off;
   logic            present;
   logic [127:0]    key_raw;
   logic [127:0]    key_out;

   logic [CW-1:0]   i_w;
   logic [CW-1:0]   i_mod;
   logic [CW-1:0]   i_div;
   logic [7:0]      rc;
   logic [31:0]     g;
   logic [31:0]     new_word;

   // Select the round key out of the window once all four of its words are present.
   always_comb begin
      r4      = CW'({r_q, 2'b00});
      off     = r4 - j_q;
      present = (state_q == StRun) && (r4 >= j_q);
      key_raw = '0;
      for (int k = 0; k + 4 <= int'(Nk); k++) begin
         if (off == CW'(k)) begin
            key_raw = {win_q[k+3], win_q[k+2], win_q[k+1], win_q[k]};
         end
      end
`ifdef AES_INV_MIXCOL_EN
      if (r_q != '0 && r_q != RW'(Nr)) begin
         key_out = {inv_mix_col(key_raw[127:96]), inv_mix_col(key_raw[95:64]),
                    inv_mix_col(key_raw[63:32]),  inv_mix_col(key_raw[31:0])};
      end else begin
         key_out = key_raw;
      end
`else
      key_out = key_raw;
`endif
   end

   // Recover w[j-1] from the top two window words by undoing the forward recurrence.
   always_comb begin
      i_w   = j_q + CW'(Nk - 1);
      i_mod = i_w % CW'(Nk);
      i_div = i_w / CW'(Nk);
      rc    = 8'h00;
      for (int n = 1; n <= 10; n++) begin
         if (i_div == CW'(n)) begin
            rc = RCON[n];
         end
      end
      if (i_mod == '0) begin
         g = sub_word(rot_word(win_q[Nk-2])) ^ {rc, 24'h000000};
      end else if (Nk > 6 && i_mod == CW'(4)) begin
         g = sub_word(win_q[Nk-2]);
      end else begin
         g = win_q[Nk-2];
      end
      new_word = win_q[Nk-1] ^ g;
   end

   // Next-state: load restarts from any state; otherwise present a key or step the window.
   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      j_d          = j_q;
      r_d          = r_q;
      done_d       = 1'b0;
      key_hold_d   = key_hold_q;
      round_hold_d = round_hold_q;
      if (present) begin
         key_hold_d   = key_out;
         round_hold_d = r_q;
      end
      if (load) begin
         for (int k = 0; k < int'(Nk); k++) begin
            win_d[k] = last_key[32*k +: 32];
         end
         j_d     = CW'(J0);
         r_d     = RW'(Nr);
         state_d = StRun;
      end else if (state_q == StRun) begin
         if (present) begin
            if (rkey_ready) begin
               if (r_q == '0) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  r_d = r_q - 1'b1;
               end
            end
         end else begin
            for (int k = int'(Nk) - 1; k > 0; k--) begin
               win_d[k] = win_q[k-1];
            end
            win_d[0] = new_word;
            j_d      = j_q - 1'b1;
         end
      end
   end

   // State, window, counters and the last-presented key held for idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         win_q        <= '{default: '0};
         j_q          <= '0;
         r_q          <= '0;
         key_hold_q   <= '0;
         round_hold_q <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_q        <= win_d;
         j_q          <= j_d;
         r_q          <= r_d;
         key_hold_q   <= key_hold_d;
         round_hold_q <= round_hold_d;
         done_q       <= done_d;
      end
   end

   // Live key while presenting, otherwise the last key shown.
   always_comb begin
      rkey_valid = present;
      rkey       = present ? key_out : key_hold_q;
      rkey_round = present ? r_q : round_hold_q;
      busy       = (state_q == StRun);
      done       = done_q;
   end

endmodule
